// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage (pre-IF + IF) of a 5-stage MIPS-style
// pipeline with one branch delay slot.
//
// pre-IF computes nextpc and issues the instruction SRAM read. IF holds the
// fetched PC and presents the returned word to decode.
//
// Optional feature macro: FS_INST_BUF_EN
//   defined   : IF keeps a copy of the returned instruction while it is
//               stalled, so decode sees a stable word even if the SRAM
//               output changes.
//   undefined : IF relies on the SRAM holding rdata while inst_sram_en=0.
//
// Ports
//   clk              in   1   clock, rising edge
//   reset            in   1   synchronous, active-high
//   ds_allowin       in   1   decode can accept this cycle
//   br_bus           in  34   {br_stall, br_taken, br_target[31:0]}
//   fs_to_ds_valid   out  1   IF holds a valid instruction
//   fs_to_ds_bus     out 64   {fs_inst[31:0], fs_pc[31:0]}
//   inst_sram_en     out  1   SRAM read enable
//   inst_sram_wen    out  4   SRAM byte write enables (always 0)
//   inst_sram_addr   out 32   SRAM read address (nextpc)
//   inst_sram_wdata  out 32   SRAM write data (always 0)
//   inst_sram_rdata  in  32   SRAM read data, one cycle after enable
// ---------------------------------------------------------------------------

// Bus widths shared with the rest of the core (same values as mycpu.h).
`ifndef BR_BUS_WD
`define BR_BUS_WD 34
`endif
`ifndef FS_TO_DS_BUS_WD
`define FS_TO_DS_BUS_WD 64
`endif

module if_stage (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ds_allowin,
  input  logic [`BR_BUS_WD-1:0]       br_bus,
  output logic                        fs_to_ds_valid,
  output logic [`FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                        inst_sram_en,
  output logic [3:0]                  inst_sram_wen,
  output logic [31:0]                 inst_sram_addr,
  output logic [31:0]                 inst_sram_wdata,
  input  logic [31:0]                 inst_sram_rdata
);

  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        r_br_pend;
  logic [31:0] r_br_pend_target;

  logic        w_br_stall;
  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_to_fs_valid;
  logic        w_fs_ready_go;
  logic        w_fs_allowin;
  logic        w_fetch;
  logic [31:0] w_seq_pc;
  logic [31:0] w_nextpc;
  logic [31:0] w_fs_inst;

  assign w_br_stall  = br_bus[33];
  assign w_br_taken  = br_bus[32];
  assign w_br_target = br_bus[31:0];

  // ---------------- pre-IF ----------------
  assign w_to_fs_valid = ~reset & ~w_br_stall;
  assign w_seq_pc      = r_fs_pc + 32'd4;

  // A redirect that arrived while IF was blocked wins over everything else;
  // otherwise a live branch redirects, else fall through sequentially.
  assign w_nextpc = r_br_pend  ? r_br_pend_target :
                    w_br_taken ? w_br_target      : w_seq_pc;

  assign w_fetch         = w_to_fs_valid & w_fs_allowin;
  assign inst_sram_en    = w_fetch;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // ---------------- IF ----------------
  assign w_fs_ready_go  = 1'b1;
  assign w_fs_allowin   = ~r_fs_valid | (w_fs_ready_go & ds_allowin);
  assign fs_to_ds_valid = r_fs_valid & w_fs_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_valid <= 1'b0;
      // One word before the boot vector so that seq_pc hits 0xbfc00000.
      r_fs_pc    <= 32'hbfbffffc;
    end else if (w_fs_allowin) begin
      r_fs_valid <= w_to_fs_valid;
      if (w_to_fs_valid) begin
        r_fs_pc <= w_nextpc;
      end
    end
  end

  // Redirect capture. A stall suppresses capture even when br_taken is also
  // set; the branch unit re-presents the redirect once the stall clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_pend        <= 1'b0;
      r_br_pend_target <= 32'h0;
    end else if (w_fetch) begin
      r_br_pend <= 1'b0;
    end else if (~w_br_stall & w_br_taken) begin
      r_br_pend        <= 1'b1;
      r_br_pend_target <= w_br_target;
    end
  end

`ifdef FS_INST_BUF_EN
  logic        r_inst_buf_valid;
  logic [31:0] r_inst_buf;

  // Snapshot rdata on the first stalled cycle; drop it when IF advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_buf_valid <= 1'b0;
      r_inst_buf       <= 32'h0;
    end else if (r_fs_valid & ds_allowin) begin
      r_inst_buf_valid <= 1'b0;
    end else if (r_fs_valid & ~ds_allowin & ~r_inst_buf_valid) begin
      r_inst_buf_valid <= 1'b1;
      r_inst_buf       <= inst_sram_rdata;
    end
  end

  assign w_fs_inst = r_inst_buf_valid ? r_inst_buf : inst_sram_rdata;
`else
  assign w_fs_inst = inst_sram_rdata;
`endif

  assign fs_to_ds_bus = {w_fs_inst, r_fs_pc};

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed self-checking bench for if_stage.
// A behavioural SRAM returns word(addr) one cycle after an enabled read and
// holds its output otherwise. Inputs change #1 after the rising edge and
// outputs are compared before the next edge.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic [31:0] r_sram_q;
  logic        corrupt = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'hbfc00010) ? 32'h12345678 : ~a;
  endfunction

  always @(posedge clk) begin
    if (inst_sram_en) r_sram_q <= word(inst_sram_addr);
  end
  assign inst_sram_rdata = corrupt ? 32'hdeadbeef : r_sram_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %0d %s observed=%h expected=%h", checks, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b1; br_bus = 34'h0;
    tick(); tick();
    // reset state
    chk("rst_valid", 64'(fs_to_ds_valid), 64'd0);
    chk("rst_en", 64'(inst_sram_en), 64'd0);
    chk("rst_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfbffffc);
    chk("wen", 64'(inst_sram_wen), 64'h0);
    chk("wdata", 64'(inst_sram_wdata), 64'h0);

    // reset release: consecutive sequential fetches
    reset = 1'b0; #1;
    chk("boot_en", 64'(inst_sram_en), 64'd1);
    chk("boot_addr0", 64'(inst_sram_addr), 64'hbfc00000);
    chk("boot_valid_pre", 64'(fs_to_ds_valid), 64'd0);
    tick();
    chk("boot_valid", 64'(fs_to_ds_valid), 64'd1);
    chk("boot_bus0", fs_to_ds_bus, {32'h403fffff, 32'hbfc00000});
    chk("boot_addr1", 64'(inst_sram_addr), 64'hbfc00004);
    tick();
    chk("boot_addr2", 64'(inst_sram_addr), 64'hbfc00008);

    // taken branch while the delay slot 0xbfc00004 sits in IF
    br_bus = {1'b0, 1'b1, 32'hbfc00100}; #1;
    chk("br_addr", 64'(inst_sram_addr), 64'hbfc00100);
    chk("br_slot_valid", 64'(fs_to_ds_valid), 64'd1);
    chk("br_slot_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfc00004);
    tick();
    br_bus = 34'h0; #1;
    chk("br_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfc00100);
    chk("br_seq_addr", 64'(inst_sram_addr), 64'hbfc00104);

    // three stall cycles, then a redirect
    br_bus = {1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_en%0d", i), 64'(inst_sram_en), 64'd0);
      tick();
      chk($sformatf("stall_pc%0d", i), 64'(fs_to_ds_bus[31:0]), 64'hbfc00100);
      chk($sformatf("stall_bubble%0d", i), 64'(fs_to_ds_valid), 64'd0);
    end
    br_bus = {1'b0, 1'b1, 32'hbfc00200}; #1;
    chk("post_stall_en", 64'(inst_sram_en), 64'd1);
    chk("post_stall_addr", 64'(inst_sram_addr), 64'hbfc00200);
    tick();
    chk("post_stall_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfc00200);

    // decode stall of four cycles with 0x12345678 in IF
    br_bus = {1'b0, 1'b1, 32'hbfc00010}; #1;
    chk("to10_addr", 64'(inst_sram_addr), 64'hbfc00010);
    tick();
    br_bus = 34'h0; ds_allowin = 1'b0; #1;
    chk("hold_en", 64'(inst_sram_en), 64'd0);
    chk("hold_bus0", fs_to_ds_bus, {32'h12345678, 32'hbfc00010});
    tick();
`ifdef FS_INST_BUF_EN
    corrupt = 1'b1;
`endif
    for (int i = 1; i < 4; i++) begin
      #1;
      chk($sformatf("hold_bus%0d", i), fs_to_ds_bus, {32'h12345678, 32'hbfc00010});
      chk($sformatf("hold_valid%0d", i), 64'(fs_to_ds_valid), 64'd1);
      tick();
    end
    ds_allowin = 1'b1; #1;
    chk("release_bus", fs_to_ds_bus, {32'h12345678, 32'hbfc00010});
    chk("release_addr", 64'(inst_sram_addr), 64'hbfc00014);
    tick();
    corrupt = 1'b0; #1;
    chk("adv_bus", fs_to_ds_bus, {32'h403fffeb, 32'hbfc00014});

    // redirect while decode is blocked goes pending
    ds_allowin = 1'b0; br_bus = {1'b0, 1'b1, 32'hbfc00300}; #1;
    chk("pend_en", 64'(inst_sram_en), 64'd0);
    tick();
    br_bus = 34'h0;
    tick();
    ds_allowin = 1'b1; #1;
    chk("pend_fetch_en", 64'(inst_sram_en), 64'd1);
    chk("pend_addr", 64'(inst_sram_addr), 64'hbfc00300);
    chk("pend_slot_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfc00014);
    tick();
    chk("pend_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfc00300);
    chk("pend_consumed", 64'(inst_sram_addr), 64'hbfc00304);

    // reset mid-stream
    reset = 1'b1; #1;
    chk("mid_rst_en", 64'(inst_sram_en), 64'd0);
    tick();
    chk("mid_rst_valid", 64'(fs_to_ds_valid), 64'd0);
    chk("mid_rst_pc", 64'(fs_to_ds_bus[31:0]), 64'hbfbffffc);
    reset = 1'b0; #1;
    chk("restart_addr", 64'(inst_sram_addr), 64'hbfc00000);
    tick();
    chk("restart_valid", 64'(fs_to_ds_valid), 64'd1);

    // stall and taken together: stall wins, nothing captured
    ds_allowin = 1'b0; br_bus = {1'b1, 1'b1, 32'hbfc00400}; #1;
    chk("both_en", 64'(inst_sram_en), 64'd0);
    tick();
    chk("both_valid_held", 64'(fs_to_ds_valid), 64'd1);
    br_bus = 34'h0; ds_allowin = 1'b1; #1;
    chk("both_no_pend", 64'(inst_sram_addr), 64'hbfc00004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide the following ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- ds_allowin, in, 1: decode stage can accept this cycle.
- br_bus, in, `BR_BUS_WD (34): {br_stall[33], br_taken[32], br_target[31:0]}.
- fs_to_ds_valid, out, 1: fetch output holds a valid instruction.
- fs_to_ds_bus, out, `FS_TO_DS_BUS_WD (64): {fs_inst[63:32], fs_pc[31:0]}.
- inst_sram_en, out, 1: instruction SRAM read enable.
- inst_sram_wen, out, 4: instruction SRAM byte write enables.
- inst_sram_addr, out, 32: instruction SRAM read address.
- inst_sram_wdata, out, 32: instruction SRAM write data.
- inst_sram_rdata, in, 32: read data, valid the cycle after an enabled read; held while inst_sram_en=0.
REQ-002 SHALL take widths from mycpu.h; no parameters.

Function
REQ-003 SHALL implement two sub-stages:
- pre-IF: computes nextpc and issues the SRAM read.
- IF: holds fs_pc and the returned instruction.
REQ-004 SHALL compute seq_pc = fs_pc + 32'd4 (modulo 2^32) and nextpc = br_taken ? br_target : seq_pc.
REQ-005 SHALL define to_fs_valid = ~reset & ~br_stall.
REQ-006 SHALL define fs_ready_go = 1, fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin), and fs_to_ds_valid = fs_valid & fs_ready_go.
REQ-007 SHALL drive inst_sram_en = to_fs_valid & fs_allowin, inst_sram_addr = nextpc, inst_sram_wen = 4'h0, and inst_sram_wdata = 32'h0.
REQ-008 SHALL, when fs_allowin=1, load fs_valid <= to_fs_valid and, if to_fs_valid=1, load fs_pc <= nextpc. Otherwise it holds fs_valid and fs_pc.
REQ-009 SHALL treat br_target as relative to the delay-slot instruction currently in IF. The delay slot is always passed to decode and never squashed.
REQ-010 SHALL, while br_stall=1, issue no fetch and keep fs_pc unchanged. If ds_allowin=1 during br_stall, fs_valid drops to 0 (bubble).
REQ-011 SHALL fetch br_target on the first cycle with br_stall=0 and br_taken=1, provided fs_allowin=1.
REQ-012 SHALL, when br_taken=1 and fs_allowin=0, hold the redirect pending in an internal register (br_pend, br_pend_target). The pending redirect is consumed on the next fetch issue and overrides REQ-004.
REQ-013 SHALL, on simultaneous br_stall=1 and br_taken=1, give br_stall priority: no fetch and no capture into br_pend.
REQ-014 SHALL keep fs_to_ds_bus stable while fs_to_ds_valid=1 and ds_allowin=0.

Reset
REQ-015 SHALL, on reset, set fs_valid=0, fs_pc=32'hbfbffffc, br_pend=0, br_pend_target=0, and clear the instruction buffer (inst_buf_valid=0, inst_buf=0).
REQ-016 SHALL drive inst_sram_en=0 during reset and fetch 32'hbfc00000 on the first cycle after reset deasserts.
REQ-017 SHALL discard any in-flight read when reset is asserted mid-operation; no instruction from before reset reaches decode.

Configuration
REQ-018 SHALL support the macro FS_INST_BUF_EN.
- Defined: a 32-bit inst_buf plus inst_buf_valid capture inst_sram_rdata on the first cycle IF is stalled (fs_valid=1, ds_allowin=0). fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata. The buffer clears on IF advance.
- Undefined: no buffer is built; fs_inst = inst_sram_rdata, relying on the SRAM hold property. Port list and cycle timing are identical in both builds.

Verification
REQ-019 SHALL cover the following directed scenarios:
- Reset release with ds_allowin=1 held: addresses 0xbfc00000, 0xbfc00004 and 0xbfc00008 are fetched on consecutive cycles; fs_to_ds_valid rises one cycle after the first fetch.
- br_taken=1 with br_target=0xbfc00100 while IF holds 0xbfc00004: the next fetch address is 0xbfc00100, and 0xbfc00004 still reaches decode.
- br_stall=1 for 3 cycles, then br_taken=1 with target 0xbfc00200: no inst_sram_en during the stall, fs_pc holds, then 0xbfc00200 is fetched.
- ds_allowin=0 for 4 cycles with the SRAM returning 0x12345678 and rdata then corrupted to 0xdeadbeef: fs_to_ds_bus keeps inst 0x12345678 (FS_INST_BUF_EN defined).
- br_taken=1 with target 0xbfc00300 while ds_allowin=0: the redirect is held in br_pend and 0xbfc00300 is fetched on the first fetch issue after ds_allowin=1.
- reset asserted mid-stream: the next cycle has fs_to_ds_valid=0; after release, fetch restarts at 0xbfc00000.
